// File: rtl/counter.sv
// Enable-gated up-counter that runs 0..MAX_VALUE and wraps to 0.
// Count is a plain register; reset is synchronous and dominates enable.
module counter #(
    parameter int          SIZE      = 10,
    parameter int unsigned MAX_VALUE = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    output logic [SIZE-1:0] count
);

    localparam logic [SIZE-1:0] MAX = SIZE'(MAX_VALUE);

    generate
        if (SIZE < 1) begin : g_bad_size
            $error("counter: SIZE must be at least 1");
        end
        if (SIZE < 32 && 64'(MAX_VALUE) >= (64'd1 << SIZE)) begin : g_bad_max
            $error("counter: MAX_VALUE does not fit in SIZE bits");
        end
    endgenerate

    logic [SIZE-1:0] next;

    generate
        if (MAX_VALUE == 0) begin : g_zero
            // A terminal count of zero pins the counter at zero.
            always_comb begin
                next = '0;
            end
        end else begin : g_count
            // Anything at or beyond the terminal value reloads zero.
            always_comb begin
                next = count + SIZE'(1);
                if (count >= MAX) begin
                    next = '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= next;
        end
    end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default build plus two parameter corners.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] cnt_def;
    logic [2:0] cnt_ovf;
    logic [3:0] cnt_zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    counter u_def (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (cnt_def)
    );

    counter #(.SIZE(3), .MAX_VALUE(7)) u_ovf (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (cnt_ovf)
    );

    counter #(.SIZE(4), .MAX_VALUE(0)) u_zero (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (cnt_zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        step();
        tests++;
        if (cnt_def !== 10'd0) begin
            fails++;
            $display("FAIL reset_def: got %0d want 0", cnt_def);
        end
        tests++;
        if (cnt_ovf !== 3'd0) begin
            fails++;
            $display("FAIL reset_ovf: got %0d want 0", cnt_ovf);
        end
        tests++;
        if (cnt_zero !== 4'd0) begin
            fails++;
            $display("FAIL reset_zero: got %0d want 0", cnt_zero);
        end
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        logic [9:0] exp_cnt;
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_cnt = 10'(i);
            tests++;
            if (cnt_def !== exp_cnt) begin
                fails++;
                $display("FAIL count_up[%0d]: got %0d want %0d",
                         i, cnt_def, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (cnt_def !== 10'd0) begin
                fails++;
                $display("FAIL reset_mid[%0d]: got %0d want 0", i, cnt_def);
            end
        end
        reset = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_hold();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (cnt_def !== 10'd0) begin
                fails++;
                $display("FAIL hold_zero[%0d]: got %0d want 0", i, cnt_def);
            end
        end
        enable = 1'b1;
        repeat (5) step();
        tests++;
        if (cnt_def !== 10'd5) begin
            fails++;
            $display("FAIL hold_load: got %0d want 5", cnt_def);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (cnt_def !== 10'd5) begin
                fails++;
                $display("FAIL hold_five[%0d]: got %0d want 5", i, cnt_def);
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_seq [11] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5,
                                     10'd6, 10'd7, 10'd8, 10'd9, 10'd0,
                                     10'd1};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            tests++;
            if (cnt_def !== exp_seq[i]) begin
                fails++;
                $display("FAIL wrap[edge %0d]: got %0d want %0d",
                         i + 1, cnt_def, exp_seq[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_corners();
        logic [2:0] exp_ovf [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                    3'd6, 3'd7, 3'd0, 3'd1};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            tests++;
            if (cnt_ovf !== exp_ovf[i]) begin
                fails++;
                $display("FAIL overflow[edge %0d]: got %0d want %0d",
                         i + 1, cnt_ovf, exp_ovf[i]);
            end
            tests++;
            if (cnt_zero !== 4'd0) begin
                fails++;
                $display("FAIL max_zero[edge %0d]: got %0d want 0",
                         i + 1, cnt_zero);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_toggle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enable = (i % 2 == 0);
            step();
        end
        tests++;
        if (cnt_def !== 10'd4) begin
            fails++;
            $display("FAIL toggle: got %0d want 4", cnt_def);
        end
        enable = 1'b1;
        repeat (5) step();
        tests++;
        if (cnt_def !== 10'd9) begin
            fails++;
            $display("FAIL reach_max: got %0d want 9", cnt_def);
        end
        reset = 1'b1;
        step();
        tests++;
        if (cnt_def !== 10'd0) begin
            fails++;
            $display("FAIL reset_at_max: got %0d want 0", cnt_def);
        end
        reset = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_count_up();
        test_reset_mid();
        test_hold();
        test_wrap();
        test_corners();
        test_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
